// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package ecap5_dproc_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [0:0] {
    HAZ_RUN,
    HAZ_FLUSH
  } haz_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters with RAW/saturation lookup and underflow error.
// HAZARD_CTL_WB_BYPASS_EN: a source whose last pending write retires this cycle counts as ready.
module reg_scoreboard
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned PENDING_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rs1,
  input  logic      uses_rs1,
  input  reg_addr_t rs2,
  input  logic      uses_rs2,
  input  logic      reg_write,
  input  reg_addr_t rd,
  input  logic      issue,
  input  logic      wb_valid,
  input  reg_addr_t wb_addr,
  output logic      hazard,
  output logic      saturated,
  output logic      pending_any,
  output logic      err
);

  typedef logic [PENDING_W-1:0] cnt_t;
  localparam cnt_t CntMax = '1;
  localparam cnt_t CntOne = cnt_t'(1);

  cnt_t cnt_q [NUM_REGS];
  cnt_t cnt_d [NUM_REGS];
  logic err_q, err_d;
  logic inc_en, dec_en;
  logic haz1, haz2;

  // x0 is masked here so it can never be counted, stalled on, or flagged.
  assign inc_en = issue && reg_write && (rd != '0);
  assign dec_en = wb_valid && (wb_addr != '0);

  always_comb begin
    haz1 = uses_rs1 && (cnt_q[rs1] != '0);
    haz2 = uses_rs2 && (cnt_q[rs2] != '0);
`ifdef HAZARD_CTL_WB_BYPASS_EN
    if (wb_valid && (wb_addr == rs1) && (cnt_q[rs1] == CntOne)) haz1 = 1'b0;
    if (wb_valid && (wb_addr == rs2) && (cnt_q[rs2] == CntOne)) haz2 = 1'b0;
`endif
    hazard    = haz1 || haz2;
    saturated = reg_write && (rd != '0) && (cnt_q[rd] == CntMax);
  end

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (dec_en && (wb_addr == reg_addr_t'(i)) && (cnt_q[i] == '0)) err_d = 1'b1;
      if (inc_en && (rd == reg_addr_t'(i))) begin
        if (!(dec_en && (wb_addr == reg_addr_t'(i)))) cnt_d[i] = cnt_q[i] + CntOne;
      end else if (dec_en && (wb_addr == reg_addr_t'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cnt_q[i] != '0) pending_any = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/hazard_ctl.sv
// Decode-stage hazard controller: gates the decode->execute handshake and sequences branch flushes.
// HAZARD_CTL_WB_BYPASS_EN (in reg_scoreboard) lets a consumer issue in its producer's write-back cycle.
module hazard_ctl
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned PENDING_W    = 2,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec_valid_i,
  input  logic [4:0] dec_raddr1_i,
  input  logic       dec_uses_rs1_i,
  input  logic [4:0] dec_raddr2_i,
  input  logic       dec_uses_rs2_i,
  input  logic       dec_reg_write_i,
  input  logic [4:0] dec_rd_i,
  input  logic       ex_ready_i,
  input  logic       branch_taken_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_addr_i,
  output logic       stall_o,
  output logic       issue_o,
  output logic       flush_o,
  output logic       pending_any_o,
  output logic       err_o
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYCLES);
  localparam logic [FlushW-1:0] FlushOne  = FlushW'(1);

  haz_state_e        state_q, state_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic              hazard, saturated;

  reg_scoreboard #(
    .PENDING_W (PENDING_W)
  ) u_scoreboard (
    .clk         (clk_i),
    .rst         (rst_i),
    .rs1         (dec_raddr1_i),
    .uses_rs1    (dec_uses_rs1_i),
    .rs2         (dec_raddr2_i),
    .uses_rs2    (dec_uses_rs2_i),
    .reg_write   (dec_reg_write_i),
    .rd          (dec_rd_i),
    .issue       (issue_o),
    .wb_valid    (wb_valid_i),
    .wb_addr     (wb_addr_i),
    .hazard      (hazard),
    .saturated   (saturated),
    .pending_any (pending_any_o),
    .err         (err_o)
  );

  always_comb begin
    stall_o = dec_valid_i &&
              (hazard || saturated || (state_q != HAZ_RUN) || branch_taken_i);
    issue_o = dec_valid_i && ex_ready_i && !stall_o;
    flush_o = (state_q == HAZ_FLUSH);
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      HAZ_RUN: begin
        if (branch_taken_i) begin
          state_d     = HAZ_FLUSH;
          flush_cnt_d = FlushLoad;
        end
      end
      HAZ_FLUSH: begin
        // A younger taken branch restarts the full flush window.
        if (branch_taken_i) begin
          flush_cnt_d = FlushLoad;
        end else if (flush_cnt_q == FlushOne) begin
          state_d = HAZ_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FlushOne;
        end
      end
      default: state_d = HAZ_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HAZ_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: vector table plus flush/reset sequences, checked via a queue.
module tb_hazard_ctl;

  logic       clk;
  logic       rst;
  logic       dec_valid, uses_rs1, uses_rs2, reg_write, ex_ready, branch_taken, wb_valid;
  logic [4:0] raddr1, raddr2, rd, wb_addr;
  logic       stall, issue, flush, pending_any, err;

  typedef struct {
    string      name;
    logic       rst;
    logic       valid;
    logic       rdy;
    logic       u1;
    logic [4:0] r1;
    logic       u2;
    logic [4:0] r2;
    logic       rw;
    logic [4:0] rd;
    logic       br;
    logic       wbv;
    logic [4:0] wa;
    logic [4:0] exp; // {stall, issue, flush, pending_any, err}
  } vec_t;

  vec_t tbl[$];
  vec_t expq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef HAZARD_CTL_WB_BYPASS_EN
  localparam logic [4:0] RawWbExp = 5'b01010;
`else
  localparam logic [4:0] RawWbExp = 5'b10010;
`endif

  hazard_ctl #(
    .PENDING_W    (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .dec_valid_i     (dec_valid),
    .dec_raddr1_i    (raddr1),
    .dec_uses_rs1_i  (uses_rs1),
    .dec_raddr2_i    (raddr2),
    .dec_uses_rs2_i  (uses_rs2),
    .dec_reg_write_i (reg_write),
    .dec_rd_i        (rd),
    .ex_ready_i      (ex_ready),
    .branch_taken_i  (branch_taken),
    .wb_valid_i      (wb_valid),
    .wb_addr_i       (wb_addr),
    .stall_o         (stall),
    .issue_o         (issue),
    .flush_o         (flush),
    .pending_any_o   (pending_any),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic rs, input logic val, input logic rdy,
                              input logic u1, input logic [4:0] r1, input logic u2,
                              input logic [4:0] r2, input logic rw, input logic [4:0] d,
                              input logic br, input logic wbv, input logic [4:0] wa,
                              input logic [4:0] exp);
    vec_t v;
    v.name = nm; v.rst = rs; v.valid = val; v.rdy = rdy; v.u1 = u1; v.r1 = r1; v.u2 = u2;
    v.r2 = r2; v.rw = rw; v.rd = d; v.br = br; v.wbv = wbv; v.wa = wa; v.exp = exp;
    return v;
  endfunction

  task automatic cmp(input string nm, input string sig, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %b, want %b", nm, sig, got, want);
    end
  endtask

  // Drive one cycle of stimulus just after the edge, check at the following negedge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst; dec_valid = v.valid; ex_ready = v.rdy; uses_rs1 = v.u1; raddr1 = v.r1;
    uses_rs2 = v.u2; raddr2 = v.r2; reg_write = v.rw; rd = v.rd; branch_taken = v.br;
    wb_valid = v.wbv; wb_addr = v.wa;
    expq.push_back(v);
    @(negedge clk);
    e = expq.pop_front();
    cmp(e.name, "stall", stall, e.exp[4]);
    cmp(e.name, "issue", issue, e.exp[3]);
    cmp(e.name, "flush", flush, e.exp[2]);
    cmp(e.name, "pending_any", pending_any, e.exp[1]);
    cmp(e.name, "err", err, e.exp[0]);
  endtask

  initial begin
    rst = 1'b1; dec_valid = 0; ex_ready = 0; uses_rs1 = 0; raddr1 = 0; uses_rs2 = 0;
    raddr2 = 0; reg_write = 0; rd = 0; branch_taken = 0; wb_valid = 0; wb_addr = 0;
    repeat (2) @(posedge clk);

    //                 name          rst val rdy u1 r1 u2 r2 rw rd br wbv wa  exp
    tbl.push_back(mk("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk("x0_write",     0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b01000));
    tbl.push_back(mk("x0_read",      0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b01000));
    tbl.push_back(mk("issue_rd5",    0, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 5'b01000));
    tbl.push_back(mk("raw_stall",    0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 5'b10010));
    tbl.push_back(mk("raw_stall2",   0, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 5'b10010));
    tbl.push_back(mk("raw_wb",       0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 1, 5, RawWbExp));
    tbl.push_back(mk("raw_resume",   0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 5'b01000));
    tbl.push_back(mk("not_ready",    0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk("sat_1",        0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 5'b01000));
    tbl.push_back(mk("sat_2",        0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 5'b01010));
    tbl.push_back(mk("sat_3",        0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 5'b01010));
    tbl.push_back(mk("sat_stall",    0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 5'b10010));
    tbl.push_back(mk("sat_wb",       0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 5'b10010));
    tbl.push_back(mk("sat_resume",   0, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 5'b01010));
    tbl.push_back(mk("drain7_a",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 5'b00010));
    tbl.push_back(mk("drain7_b",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 5'b00010));
    tbl.push_back(mk("drain7_c",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 5'b00010));
    tbl.push_back(mk("drained",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk("issue_rd3",    0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 5'b01000));
    tbl.push_back(mk("inc_dec_3",    0, 1, 1, 0, 0, 0, 0, 1, 3, 0, 1, 3, 5'b01010));
    tbl.push_back(mk("cnt3_held",    0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 5'b10010));
    tbl.push_back(mk("wb3",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5'b00010));
    tbl.push_back(mk("cnt3_zero",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk("wb_x0",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000));
    tbl.push_back(mk("x0_no_err",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk("wb_x9_zero",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 5'b00000));
    tbl.push_back(mk("err_set",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001));
    tbl.push_back(mk("err_sticky",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01001));

    foreach (tbl[i]) apply(tbl[i]);

    // Single branch: stall in N, flush N+1..N+2, issue again at N+3.
    apply(mk("br_n",        0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10001));
    apply(mk("br_n1",       0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10101));
    apply(mk("br_n2",       0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10101));
    apply(mk("br_resume",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01001));

    // Second branch one cycle into the flush extends it by one cycle.
    apply(mk("br2_n",       0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10001));
    apply(mk("br2_reload",  0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b10101));
    apply(mk("br2_noval",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101));
    apply(mk("br2_ext",     0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10101));
    apply(mk("br2_resume",  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01001));

    // Reset mid-flush with a write pending; a late write-back then flags err.
    apply(mk("rst_issue12", 0, 1, 1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 5'b01001));
    apply(mk("rst_br",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00011));
    apply(mk("rst_in_fl",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00111));
    apply(mk("rst_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
    apply(mk("late_wb12",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 5'b00000));
    apply(mk("late_err",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
